add_sequencer: RTL and testbench
================================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25_000_000, clock cycles per blink half-period (minimum 2).
REQ-002 SHALL have port clk input 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset input 1: synchronous, active-high reset.
REQ-004 SHALL have port enter input 1: debounced, active-high pushbutton level; one press is one rising edge.
REQ-005 SHALL have port clear input 1: active-high level; synchronous return to operand-A entry.
REQ-006 SHALL have port sw_in input 4: operand value from the switches.
REQ-007 SHALL have port sum_in input 5: combinational 5-bit sum from the external 4-bit adder, computed as op_a+op_b.
REQ-008 SHALL have ports op_a and op_b, each output 4: registered adder operands, also shown on the operand displays.
REQ-009 SHALL have port result output 5: registered captured sum.
REQ-010 SHALL have port state output 2: current FSM state encoding.
REQ-011 SHALL have ports blank_a, blank_b and blank_r, each output 1: when 1, the matching 7-seg digit pair is blanked.

Function
REQ-012 SHALL implement FSM states S_A=00, S_B=01, S_ADD=10, S_SHOW=11.
REQ-013 SHALL register enter into enter_q every cycle and define press = enter & ~enter_q.
REQ-014 S_A: op_a SHALL load sw_in every cycle; on press, op_a SHALL load sw_in and the FSM SHALL move to S_B.
REQ-015 S_B: op_a SHALL hold and op_b SHALL load sw_in every cycle; on press, op_b SHALL load sw_in and the FSM SHALL move to S_ADD.
REQ-016 S_ADD: result SHALL load sum_in and the FSM SHALL move to S_SHOW unconditionally; this state lasts exactly 1 cycle and press is ignored.
REQ-017 S_SHOW: op_a, op_b and result SHALL hold; on press, the FSM SHALL move to S_A, and result SHALL be zeroed.
REQ-018 Latency: result SHALL be valid, and state SHALL read S_SHOW, 2 cycles after the cycle in which the operand-B press is sampled.
REQ-019 clear SHALL, in any state, set the FSM to S_A and set op_b and result to 0; op_a SHALL load sw_in that cycle.
REQ-020 clear SHALL take priority over a simultaneous press, and that press SHALL be consumed.
REQ-021 A held enter SHALL generate exactly one press; a release-and-repress SHALL be required for the next press.
REQ-022 The blink counter SHALL count 0..BLINK_DIV-1 and wrap to 0; on the wrap cycle the blink bit SHALL toggle.
REQ-023 The blink counter SHALL run in every state, and clear SHALL NOT affect it.
REQ-024 Blanking SHALL follow this table:
  - blank_a = blink in S_A, else 0.
  - blank_b = blink in S_B, else 0.
  - blank_r = 0 in S_SHOW, else 1.
REQ-025 result SHALL carry the full 5-bit sum, with no truncation; maximum 15+15 = 30 = 5'b11110.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL set:
  - state = S_A
  - op_a = 0, op_b = 0, result = 0
  - blink counter = 0, blink = 0
  - enter_q = 1, so a button held through reset is not counted as a press.
REQ-027 reset SHALL override clear and enter, including when reset is applied mid-sequence (S_B or S_ADD).
REQ-028 All outputs SHALL be register-driven or decoded from state and blink only, with no combinational path from the inputs.

Verification (BLINK_DIV=4, adder model sum_in=op_a+op_b)
REQ-029 Basic add: reset, sw_in=3, press, sw_in=5, press -> state 10 for 1 cycle, then 11 with result=8 and blank_r=0.
REQ-030 Overflow: op_a=15, op_b=15 -> result=5'b11110; a press in S_SHOW -> state 00, result=0, blank_r=1.
REQ-031 Held button: enter held high for 20 cycles starting in S_A -> exactly one advance, to S_B.
REQ-032 Held button: enter held through reset release -> no advance until enter goes low and then high again.
REQ-033 Clear priority: in S_B, assert clear and a press in the same cycle -> state 00, op_b=0, result=0, next state not S_ADD.
REQ-034 Blink: in S_A, blank_a toggles every 4 cycles with blank_b=0.
REQ-035 Blink: in S_B, blank_b toggles every 4 cycles with blank_a=0.
REQ-036 Blink: in S_SHOW, blank_a=0 and blank_b=0.

Source files
------------

// File: rtl/add_sequencer.sv
// -----------------------------------------------------------------------------
// add_sequencer
// Operand-entry sequencer for a 4-bit adder demo board. The user dials operand
// A on the switches and presses enter. The user then dials operand B and
// presses enter again. The externally computed sum is captured one cycle later
// and held for display until the next press. While an operand is being entered,
// its 7-segment digit pair blinks.
//
// Parameters
//   BLINK_DIV   clock cycles per blink half-period (minimum 2)
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   enter       debounced pushbutton level (one press = one rising edge)
//   clear       synchronous return to operand-A entry
//   sw_in[3:0]  operand value from the switches
//   sum_in[4:0] op_a + op_b from the external adder
//   op_a/op_b   registered adder operands (also shown on the displays)
//   result[4:0] registered captured sum
//   state[1:0]  FSM state: 00 A, 01 B, 10 ADD, 11 SHOW
//   blank_a/b/r digit-pair blanking for operand A, operand B and result
// -----------------------------------------------------------------------------
module add_sequencer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       clear,
    input  logic [3:0] sw_in,
    input  logic [4:0] sum_in,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [4:0] result,
    output logic [1:0] state,
    output logic       blank_a,
    output logic       blank_b,
    output logic       blank_r
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_ADD  = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    localparam int            CW        = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] BLINK_MAX = CW'(BLINK_DIV - 1);

    state_t        r_state,  w_state_nxt;
    logic [3:0]    r_op_a,   w_op_a_nxt;
    logic [3:0]    r_op_b,   w_op_b_nxt;
    logic [4:0]    r_result, w_result_nxt;
    logic          r_enter_q;
    logic          w_press;
    logic [CW-1:0] r_blink_cnt;
    logic          r_blink;

    // A press is the first cycle that enter is high. enter_q resets high, so a
    // button that is held through reset does not count as a press.
    assign w_press = enter & ~r_enter_q;

    // Next-state and datapath decode. clear is checked first, so it wins over
    // a press in the same cycle. Because enter_q still samples enter in that
    // cycle, the press is consumed and is not seen again.
    always_comb begin
        // NOTE: every output of this block is given a default first. With the
        // defaults, no path leaves a variable unassigned, so no latch is inferred.
        w_state_nxt  = r_state;
        w_op_a_nxt   = r_op_a;
        w_op_b_nxt   = r_op_b;
        w_result_nxt = r_result;

        if (clear) begin
            w_state_nxt  = S_A;
            w_op_a_nxt   = sw_in;
            w_op_b_nxt   = 4'd0;
            w_result_nxt = 5'd0;
        end else begin
            case (r_state)
                S_A: begin
                    w_op_a_nxt = sw_in;
                    if (w_press) w_state_nxt = S_B;
                end
                S_B: begin
                    w_op_b_nxt = sw_in;
                    if (w_press) w_state_nxt = S_ADD;
                end
                S_ADD: begin
                    // This state lasts one cycle. In this cycle the operands are
                    // stable in the registers, so the external adder output is
                    // valid.
                    w_result_nxt = sum_in;
                    w_state_nxt  = S_SHOW;
                end
                S_SHOW: begin
                    if (w_press) begin
                        w_state_nxt  = S_A;
                        w_result_nxt = 5'd0;
                    end
                end
                default: w_state_nxt = S_A;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments. Every register then
    // samples the values from before the edge, whatever the order of the statements.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_A;
            r_op_a    <= 4'd0;
            r_op_b    <= 4'd0;
            r_result  <= 5'd0;
            r_enter_q <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_op_a    <= w_op_a_nxt;
            r_op_b    <= w_op_b_nxt;
            r_result  <= w_result_nxt;
            r_enter_q <= enter;
        end
    end

    // Free-running blink timebase. It runs in every state and clear does not
    // affect it, so the blink rate stays steady while the user re-enters values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // All outputs come from registers or are decoded from state and blink
    // only. There is no combinational path from an input to an output.
    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign result  = r_result;
    assign state   = r_state;
    assign blank_a = (r_state == S_A) & r_blink;
    assign blank_b = (r_state == S_B) & r_blink;
    assign blank_r = (r_state != S_SHOW);

endmodule

// File: tb/tb_add_sequencer.sv
module tb_add_sequencer;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset, enter, clear;
    logic [3:0] sw_in;
    logic [4:0] sum_in;
    logic [3:0] op_a, op_b;
    logic [4:0] result;
    logic [1:0] state;
    logic       blank_a, blank_b, blank_r;

    int checks   = 0;
    int failures = 0;

    // External 4-bit adder feeding the DUT.
    assign sum_in = {1'b0, op_a} + {1'b0, op_b};

    add_sequencer #(.BLINK_DIV(BD)) dut (
        .clk     (clk),
        .reset   (reset),
        .enter   (enter),
        .clear   (clear),
        .sw_in   (sw_in),
        .sum_in  (sum_in),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (result),
        .state   (state),
        .blank_a (blank_a),
        .blank_b (blank_b),
        .blank_r (blank_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural reference model ----------------
    // Phase: 0 = entering A, 1 = entering B, 2 = adding, 3 = showing.
    // The blink level is derived from the number of edges since the last reset.
    logic [1:0] m_state;
    logic [3:0] m_a, m_b;
    logic [4:0] m_res;
    logic       m_prev_enter;
    int         m_n;
    logic       m_valid = 1'b0;
    wire        m_press = enter & ~m_prev_enter;

    always @(posedge clk) begin
        if (reset) begin
            m_state      <= 2'd0;
            m_a          <= 4'd0;
            m_b          <= 4'd0;
            m_res        <= 5'd0;
            m_n          <= 0;
            m_prev_enter <= 1'b1;
            m_valid      <= 1'b1;
        end else begin
            m_n          <= m_n + 1;
            m_prev_enter <= enter;
            if (clear) begin
                m_state <= 2'd0;
                m_a     <= sw_in;
                m_b     <= 4'd0;
                m_res   <= 5'd0;
            end else if (m_state == 2'd0) begin
                m_a <= sw_in;
                if (m_press) m_state <= 2'd1;
            end else if (m_state == 2'd1) begin
                m_b <= sw_in;
                if (m_press) m_state <= 2'd2;
            end else if (m_state == 2'd2) begin
                m_res   <= 5'(m_a) + 5'(m_b);
                m_state <= 2'd3;
            end else if (m_press) begin
                m_state <= 2'd0;
                m_res   <= 5'd0;
            end
        end
    end

    // Compare process: checks every output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            automatic logic blink = ((m_n / BD) % 2) == 1;
            check("cmp_state",   32'(state),   32'(m_state));
            check("cmp_op_a",    32'(op_a),    32'(m_a));
            check("cmp_op_b",    32'(op_b),    32'(m_b));
            check("cmp_result",  32'(result),  32'(m_res));
            check("cmp_blank_a", 32'(blank_a), 32'((m_state == 2'd0) && blink));
            check("cmp_blank_b", 32'(blank_b), 32'((m_state == 2'd1) && blink));
            check("cmp_blank_r", 32'(blank_r), 32'(m_state != 2'd3));
        end
    end

    // ---------------- directed scenarios with literal expectations ----------------
    initial begin
        logic [11:0] pat;
        int          changes;
        logic        prev;

        reset = 1'b1; enter = 1'b0; clear = 1'b0; sw_in = 4'd0;
        cyc(2);
        check("rst_state",   32'(state),   32'd0);
        check("rst_result",  32'(result),  32'd0);
        check("rst_op_b",    32'(op_b),    32'd0);
        check("rst_blank_r", 32'(blank_r), 32'd1);
        check("rst_blank_a", 32'(blank_a), 32'd0);
        reset = 1'b0;

        // Basic add: 3 + 5
        sw_in = 4'd3; cyc(1);
        enter = 1'b1; cyc(1);
        check("add_to_b",  32'(state), 32'd1);
        check("add_op_a",  32'(op_a),  32'd3);
        enter = 1'b0; sw_in = 4'd5; cyc(1);
        enter = 1'b1; cyc(1);
        check("add_in_add", 32'(state), 32'd2);
        enter = 1'b0; cyc(1);
        check("add_show",     32'(state),   32'd3);
        check("add_result",   32'(result),  32'd8);
        check("add_blank_r",  32'(blank_r), 32'd0);
        cyc(5);
        check("show_blank_a", 32'(blank_a), 32'd0);
        check("show_blank_b", 32'(blank_b), 32'd0);
        check("show_hold",    32'(result),  32'd8);

        // A press in SHOW returns to A and zeroes the result.
        enter = 1'b1; cyc(1);
        check("show_exit_state",  32'(state),   32'd0);
        check("show_exit_result", 32'(result),  32'd0);
        check("show_exit_blank",  32'(blank_r), 32'd1);
        enter = 1'b0;

        // Overflow: 15 + 15 = 30
        sw_in = 4'd15; cyc(1);
        enter = 1'b1; cyc(1); enter = 1'b0; cyc(1);
        enter = 1'b1; cyc(1); enter = 1'b0; cyc(1);
        check("ovf_result", 32'(result), 32'd30);
        enter = 1'b1; cyc(1);
        check("ovf_exit_state",  32'(state),  32'd0);
        check("ovf_exit_result", 32'(result), 32'd0);
        enter = 1'b0; cyc(1);

        // Held button: 20 cycles high gives exactly one advance.
        enter = 1'b1; cyc(20);
        check("held_one_adv", 32'(state), 32'd1);
        enter = 1'b0; cyc(1);

        // Button held through reset release.
        enter = 1'b1; reset = 1'b1; cyc(2);
        reset = 1'b0; cyc(5);
        check("held_rst_no_adv", 32'(state), 32'd0);
        enter = 1'b0; cyc(1);
        enter = 1'b1; cyc(1);
        check("held_rst_repress", 32'(state), 32'd1);
        enter = 1'b0; cyc(1);

        // Clear priority in B: press and clear in the same cycle.
        enter = 1'b1; clear = 1'b1; sw_in = 4'd9; cyc(1);
        check("clr_state",  32'(state),  32'd0);
        check("clr_op_b",   32'(op_b),   32'd0);
        check("clr_result", 32'(result), 32'd0);
        check("clr_op_a",   32'(op_a),   32'd9);
        clear = 1'b0; cyc(1);
        check("clr_consumed", 32'(state), 32'd0);
        enter = 1'b0; cyc(1);

        // Reset in ADD.
        enter = 1'b1; cyc(1); enter = 1'b0; cyc(1);
        enter = 1'b1; cyc(1);
        check("mid_in_add", 32'(state), 32'd2);
        enter = 1'b0; reset = 1'b1; cyc(1);
        check("mid_rst_state",  32'(state),  32'd0);
        check("mid_rst_result", 32'(result), 32'd0);

        // Blink in A, with the phase known from reset.
        reset = 1'b0;
        pat = 12'b1_0000_1111_000;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            check("blink_a", 32'(blank_a), 32'(pat[i-1]));
            check("blink_a_b0", 32'(blank_b), 32'd0);
        end

        // Blink in B: two toggles over 8 edges, with blank_a low.
        enter = 1'b1; cyc(1); enter = 1'b0;
        prev = blank_b; changes = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (blank_b != prev) changes++;
            prev = blank_b;
            check("blink_b_a0", 32'(blank_a), 32'd0);
        end
        check("blink_b_toggles", 32'(changes), 32'd2);

        // Random traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            sw_in = 4'($urandom);
            enter = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        reset = 1'b0; clear = 1'b0; enter = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
